// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback block.
package wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned NREG   = 2 ** IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {IDLE, DRAIN, FULL} wb_state_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: ALU and load inputs, register-file write port and busy scoreboard.
interface regfile_writeback_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic [IDX_W-1:0]  alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_issue;
    logic [IDX_W-1:0]  ld_issue_rd;
    logic              ld_resp_valid;
    logic [IDX_W-1:0]  ld_resp_rd;
    logic [DATA_W-1:0] ld_resp_data;
    logic              ld_resp_ready;
    logic              reg_write;
    logic [IDX_W-1:0]  write_index;
    logic [DATA_W-1:0] write_data;
    logic [NREG-1:0]   busy;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_rd, ld_resp_data,
        input  alu_ready, ld_resp_ready, reg_write, write_index, write_data, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
               ld_resp_valid, ld_resp_rd, ld_resp_data,
        output alu_ready, ld_resp_ready, reg_write, write_index, write_data, busy
    );

endinterface

// File: rtl/wb_skid_fifo.sv
// Small FIFO holding ALU results deferred behind load responses; synchronous clear.
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_req_t          push_req,
    input  logic             pop,
    output wb_req_t          head_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = push_req;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback: load/FIFO/ALU priority merge, skid FSM, output register, busy scoreboard.
// Optional WB_CONFLICT_CNT_EN adds a saturating load-vs-ALU conflict counter.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic clk,
    input  logic RST,
    regfile_writeback_if.slave wb
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0] conflict_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    wb_state_t         state_q, state_d;
    logic              reg_write_q, reg_write_d;
    logic [IDX_W-1:0]  write_index_q, write_index_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic [CNT_W-1:0]  fifo_count;
    wb_req_t           fifo_head;
    wb_req_t           alu_req;
    wb_req_t           win_req;
    logic              win_valid;
    logic              push, pop;
    logic              ld_acc, alu_acc, fifo_nempty;

    assign fifo_nempty      = (fifo_count != '0);
    assign wb.alu_ready     = (fifo_count < CNT_W'(BUF_DEPTH)) & ~RST;
    assign wb.ld_resp_ready = ~RST;
    assign ld_acc           = wb.ld_resp_valid & ~RST;
    assign alu_acc          = wb.alu_valid & wb.alu_ready;
    assign alu_req          = '{rd: wb.alu_rd, data: wb.alu_data};

    wb_skid_fifo #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk      (clk),
        .rst      (RST),
        .push     (push),
        .push_req (alu_req),
        .pop      (pop),
        .head_c   (fifo_head),
        .count    (fifo_count)
    );

    // Winner select; an accepted ALU result that cannot go direct joins the FIFO tail.
    always_comb begin
        win_valid = 1'b0;
        win_req   = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (ld_acc) begin
            win_valid = 1'b1;
            win_req   = '{rd: wb.ld_resp_rd, data: wb.ld_resp_data};
            push      = alu_acc;
        end else if (fifo_nempty) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
            pop       = 1'b1;
            push      = alu_acc;
        end else if (alu_acc) begin
            win_valid = 1'b1;
            win_req   = alu_req;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (push && !pop) state_d = (BUF_DEPTH == 1) ? FULL : DRAIN;
            DRAIN: begin
                if (push && !pop && fifo_count == CNT_W'(BUF_DEPTH - 1)) state_d = FULL;
                else if (pop && !push && fifo_count == CNT_W'(1))        state_d = IDLE;
            end
            FULL:  if (pop && !push) state_d = (BUF_DEPTH == 1) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // x0 writes are swallowed: the write port holds its previous index/data.
    always_comb begin
        reg_write_d   = win_valid && (win_req.rd != '0);
        write_index_d = write_index_q;
        write_data_d  = write_data_q;
        if (reg_write_d) begin
            write_index_d = win_req.rd;
            write_data_d  = win_req.data;
        end
        busy_d = busy_q;
        if (ld_acc)      busy_d[wb.ld_resp_rd]  = 1'b0;
        if (wb.ld_issue) busy_d[wb.ld_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q       <= IDLE;
            reg_write_q   <= 1'b0;
            write_index_q <= '0;
            write_data_q  <= '0;
            busy_q        <= '0;
        end else begin
            state_q       <= state_d;
            reg_write_q   <= reg_write_d;
            write_index_q <= write_index_d;
            write_data_q  <= write_data_d;
            busy_q        <= busy_d;
        end
    end

    assign wb.reg_write   = reg_write_q;
    assign wb.write_index = write_index_q;
    assign wb.write_data  = write_data_q;
    assign wb.busy        = busy_q;

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        conflict;

    assign conflict = ld_acc & (wb.alu_valid | fifo_nempty);

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && conflict_cnt_q != 16'hFFFF) conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (RST) conflict_cnt_q <= '0;
        else     conflict_cnt_q <= conflict_cnt_d;
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
